// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB,
// drives the shared datapath and counts retired instructions.
module multicycle_control_unit #(
  parameter int OP_W      = 6,
  parameter int ALUCTRL_W = 3,
  parameter int CNT_W     = 32,
  parameter bit WAIT_EN   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OP_W-1:0]      opcode_in,
  input  logic [OP_W-1:0]      funccode_in,
  input  logic                 alu_zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic [1:0]           pc_source,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 reg_dst,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic [1:0]           sig_extend_signal,
  output logic [2:0]           state_out,
  output logic                 illegal_op,
  output logic [CNT_W-1:0]     instr_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;

  localparam logic [OP_W-1:0] OP_R     = OP_W'(6'h00);
  localparam logic [OP_W-1:0] FN_ADD   = OP_W'(6'h20);
  localparam logic [OP_W-1:0] OP_ADDIU = OP_W'(6'h09);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'h0D);
  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(6'h0F);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'h23);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'h2B);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'h04);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'h02);

  localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(3'b010);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(3'b110);
  localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(3'b001);

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [CNT_W-1:0] r_count;
  logic             w_rdy;
  logic             w_retire;
  logic             w_is_add;
  logic             w_is_addiu;
  logic             w_is_ori;
  logic             w_is_lui;
  logic             w_is_lw;
  logic             w_is_sw;
  logic             w_is_beq;
  logic             w_is_j;
  logic             w_legal;
  logic             w_unused;

  // alu_zero qualifies pc_write_cond inside the datapath
  assign w_unused = alu_zero;

  assign w_rdy      = WAIT_EN ? mem_ready : 1'b1;
  assign w_is_add   = (opcode_in == OP_R) && (funccode_in == FN_ADD);
  assign w_is_addiu = (opcode_in == OP_ADDIU);
  assign w_is_ori   = (opcode_in == OP_ORI);
  assign w_is_lui   = (opcode_in == OP_LUI);
  assign w_is_lw    = (opcode_in == OP_LW);
  assign w_is_sw    = (opcode_in == OP_SW);
  assign w_is_beq   = (opcode_in == OP_BEQ);
  assign w_is_j     = (opcode_in == OP_J);
  assign w_legal    = w_is_add | w_is_addiu | w_is_ori
                    | w_is_lui | w_is_lw | w_is_sw
                    | w_is_beq | w_is_j;

  assign w_retire = ((r_state == S_DECODE) && w_is_j)
                  | ((r_state == S_EXEC) && w_is_beq)
                  | ((r_state == S_MEM) && w_is_sw && w_rdy)
                  | (r_state == S_WB);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_count <= r_count + CNT_W'(1);
    end
  end

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  w_next = w_rdy ? S_DECODE : S_FETCH;
      S_DECODE: w_next = (w_legal && !w_is_j) ? S_EXEC : S_FETCH;
      S_EXEC: begin
        w_next = S_FETCH;
        if (w_is_lw || w_is_sw) w_next = S_MEM;
        else if (w_is_add || w_is_addiu || w_is_ori || w_is_lui)
          w_next = S_WB;
      end
      S_MEM: begin
        w_next = S_MEM;
        if (w_rdy) w_next = w_is_lw ? S_WB : S_FETCH;
      end
      S_WB:     w_next = S_FETCH;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    pc_write          = 1'b0;
    pc_write_cond     = 1'b0;
    pc_source         = 2'd0;
    i_or_d            = 1'b0;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    ir_write          = 1'b0;
    reg_write         = 1'b0;
    mem_to_reg        = 1'b0;
    reg_dst           = 1'b0;
    alu_src_a         = 1'b0;
    alu_src_b         = 2'd0;
    alu_control       = '0;
    sig_extend_signal = 2'd0;
    illegal_op        = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read    = 1'b1;
        ir_write    = w_rdy;
        pc_write    = w_rdy;
        alu_src_b   = 2'd1;
        alu_control = ALU_ADD;
      end
      S_DECODE: begin
        alu_src_b         = 2'd3;
        alu_control       = ALU_ADD;
        sig_extend_signal = 2'd1;
        illegal_op        = !w_legal;
        if (w_is_j) begin
          pc_write  = 1'b1;
          pc_source = 2'd2;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        unique case (1'b1)
          w_is_add: alu_control = ALU_ADD;
          w_is_addiu, w_is_lw, w_is_sw: begin
            alu_src_b         = 2'd2;
            sig_extend_signal = 2'd1;
            alu_control       = ALU_ADD;
          end
          w_is_ori: begin
            alu_src_b   = 2'd2;
            alu_control = ALU_OR;
          end
          w_is_lui: begin
            alu_src_b         = 2'd2;
            sig_extend_signal = 2'd2;
            alu_control       = ALU_OR;
          end
          w_is_beq: begin
            alu_control   = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_source     = 2'd1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = w_is_lw;
        mem_write = w_is_sw;
      end
      S_WB: begin
        reg_write   = 1'b1;
        mem_to_reg  = w_is_lw;
        reg_dst     = w_is_add;
        alu_control = (w_is_ori || w_is_lui) ? ALU_OR : ALU_ADD;
      end
      default: ;
    endcase
  end

  assign state_out   = r_state;
  assign instr_count = r_count;

endmodule
